// File: rtl/disp_sched.sv
// Display scheduler: arbitrates the normal FSM view against countdown-done and alarm-ring overlays.
// All outputs registered, request-to-display latency 1 cycle; pulse inputs, no backpressure.
module disp_sched #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int RING_SEC = 10,
    parameter int DONE_SEC = 3
) (
    input  logic        clk_sys,
    input  logic        rstn,
    input  logic [5:0]  mode_state,
    input  logic [19:0] mode_time,
    input  logic [19:0] alarm_time,
    input  logic        ring_req,
    input  logic        cnt_done_req,
    input  logic        key_cancel,
    output logic [5:0]  state_info,
    output logic [19:0] time_data,
    output logic        ovl_active,
    output logic [1:0]  ovl_src,
    output logic        ring_end
);

    localparam int HS = CLK_HZ / 2;
    localparam int CW = (HS > 1) ? $clog2(HS) : 1;
    localparam logic [CW-1:0] HS_LAST   = CW'(HS - 1);
    localparam logic [6:0]    RING_LAST = 7'(2 * RING_SEC - 1);
    localparam logic [6:0]    DONE_LAST = 7'(2 * DONE_SEC - 1);
    localparam logic [6:0]    HSN_MAX   = 7'h7F;

    localparam logic [1:0] ST_NORM = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd1;
    localparam logic [1:0] ST_RING = 2'd2;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_DONE = 2'b01;
    localparam logic [1:0] SRC_RING = 2'b10;

    localparam logic [5:0] SI_COUNT     = 6'b000_011;
    localparam logic [5:0] SI_ALARM_ON  = 6'b001_010;
    localparam logic [5:0] SI_ALARM_OFF = 6'b000_010;

    typedef struct packed {
        logic [5:0]  info;
        logic [19:0] tdat;
        logic        act;
        logic [1:0]  src;
        logic        rend;
    } view_t;

    logic [1:0]    state_q, state_d;
    logic          pend_ring_q, pend_ring_d;
    logic          pend_done_q, pend_done_d;
    logic [CW-1:0] hs_cnt_q, hs_cnt_d;
    logic [6:0]    hs_n_q, hs_n_d;
    logic          phase_q, phase_d;
    view_t         view_q, view_d;

    logic hs_tick;
    logic expire;
    logic cancel;
    logic clr_ring;
    logic clr_done;
    logic reload;

    // Expiry/cancel only ever clear the flag of the overlay currently on screen;
    // a request in the same cycle re-latches its flag regardless.
    always_comb begin
        hs_tick     = (state_q != ST_NORM) && (hs_cnt_q == HS_LAST);
        expire      = hs_tick && (hs_n_q == ((state_q == ST_RING) ? RING_LAST : DONE_LAST));
        cancel      = key_cancel && (state_q != ST_NORM);
        clr_ring    = (state_q == ST_RING) && (expire || cancel);
        clr_done    = (state_q == ST_DONE) && (expire || cancel);
        pend_ring_d = (pend_ring_q && !clr_ring) || ring_req;
        pend_done_d = (pend_done_q && !clr_done) || cnt_done_req;

        if (pend_ring_d) begin
            state_d = ST_RING;
        end else if (pend_done_d) begin
            state_d = ST_DONE;
        end else begin
            state_d = ST_NORM;
        end

        reload = (state_d != state_q)
              || ((state_d == ST_RING) && ring_req)
              || ((state_d == ST_DONE) && cnt_done_req);
    end

    // Half-second prescaler and overlay timer; idle in NORM, restarted on every grant or retrigger.
    always_comb begin
        hs_cnt_d = '0;
        hs_n_d   = '0;
        phase_d  = 1'b1;
        if ((state_d != ST_NORM) && !reload) begin
            if (hs_tick) begin
                hs_cnt_d = '0;
                hs_n_d   = (hs_n_q == HSN_MAX) ? HSN_MAX : hs_n_q + 7'd1;
                phase_d  = ~phase_q;
            end else begin
                hs_cnt_d = hs_cnt_q + CW'(1);
                hs_n_d   = hs_n_q;
                phase_d  = phase_q;
            end
        end
    end

    always_comb begin
        view_d      = '0;
        view_d.rend = (state_q == ST_RING) && (state_d != ST_RING);
        case (state_d)
            ST_RING: begin
                view_d.info = phase_d ? SI_ALARM_ON : SI_ALARM_OFF;
                view_d.tdat = alarm_time;
                view_d.act  = 1'b1;
                view_d.src  = SRC_RING;
            end
            ST_DONE: begin
                view_d.info = SI_COUNT;
                view_d.tdat = 20'h0;
                view_d.act  = 1'b1;
                view_d.src  = SRC_DONE;
            end
            default: begin
                view_d.info = mode_state;
                view_d.tdat = mode_time;
                view_d.act  = 1'b0;
                view_d.src  = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rstn) begin
            state_q     <= ST_NORM;
            pend_ring_q <= 1'b0;
            pend_done_q <= 1'b0;
            hs_cnt_q    <= '0;
            hs_n_q      <= '0;
            phase_q     <= 1'b0;
            view_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_ring_q <= pend_ring_d;
            pend_done_q <= pend_done_d;
            hs_cnt_q    <= hs_cnt_d;
            hs_n_q      <= hs_n_d;
            phase_q     <= phase_d;
            view_q      <= view_d;
        end
    end

    assign state_info = view_q.info;
    assign time_data  = view_q.tdat;
    assign ovl_active = view_q.act;
    assign ovl_src    = view_q.src;
    assign ring_end   = view_q.rend;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched at CLK_HZ=8 (HS=4), RING_SEC=2, DONE_SEC=1.
module tb_disp_sched;

    localparam logic [5:0]  MS = 6'h01;
    localparam logic [19:0] MT = 20'h12345;
    localparam logic [19:0] AT = 20'h07300;

    logic        clk_sys = 1'b0;
    logic        rstn;
    logic [5:0]  mode_state;
    logic [19:0] mode_time;
    logic [19:0] alarm_time;
    logic        ring_req;
    logic        cnt_done_req;
    logic        key_cancel;
    logic [5:0]  state_info;
    logic [19:0] time_data;
    logic        ovl_active;
    logic [1:0]  ovl_src;
    logic        ring_end;

    always #5 clk_sys = ~clk_sys;

    disp_sched #(.CLK_HZ(8), .RING_SEC(2), .DONE_SEC(1)) dut (
        .clk_sys      (clk_sys),
        .rstn         (rstn),
        .mode_state   (mode_state),
        .mode_time    (mode_time),
        .alarm_time   (alarm_time),
        .ring_req     (ring_req),
        .cnt_done_req (cnt_done_req),
        .key_cancel   (key_cancel),
        .state_info   (state_info),
        .time_data    (time_data),
        .ovl_active   (ovl_active),
        .ovl_src      (ovl_src),
        .ring_end     (ring_end)
    );

    typedef struct packed {
        logic [5:0]  si;
        logic [19:0] td;
        logic        act;
        logic [1:0]  src;
        logic        re;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    string tname = "init";
    int    tidx  = 0;

    function automatic exp_t e_rst();
        exp_t e;
        e.si = 6'h00; e.td = 20'h0; e.act = 1'b0; e.src = 2'b00; e.re = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_norm(input logic re);
        exp_t e;
        e.si = MS; e.td = MT; e.act = 1'b0; e.src = 2'b00; e.re = re;
        return e;
    endfunction

    function automatic exp_t e_done(input logic re);
        exp_t e;
        e.si = 6'h03; e.td = 20'h0; e.act = 1'b1; e.src = 2'b01; e.re = re;
        return e;
    endfunction

    function automatic exp_t e_ring(input logic ph);
        exp_t e;
        e.si = ph ? 6'h0A : 6'h02; e.td = AT; e.act = 1'b1; e.src = 2'b10; e.re = 1'b0;
        return e;
    endfunction

    // i is the 1-based cycle index within a ring overlay; phase flips every 4 cycles.
    function automatic logic ring_ph(input int i);
        return (((i - 1) / 4) % 2) == 0;
    endfunction

    task automatic cyc(input logic rn, input logic rr, input logic cd, input logic kc, input exp_t e);
        rstn         = rn;
        ring_req     = rr;
        cnt_done_req = cd;
        key_cancel   = kc;
        @(posedge clk_sys);
        exp_q.push_back(e);
        name_q.push_back($sformatf("%s.%0d", tname, tidx));
        tidx++;
        #1;
        ring_req     = 1'b0;
        cnt_done_req = 1'b0;
        key_cancel   = 1'b0;
    endtask

    task automatic idle(input exp_t e);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic start(input string n);
        tname = n;
        tidx  = 0;
    endtask

    always @(negedge clk_sys) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if ({state_info, time_data, ovl_active, ovl_src, ring_end} !== e) begin
                bad++;
                $display("FAIL %s: got si=%h td=%h act=%b src=%b re=%b, want si=%h td=%h act=%b src=%b re=%b",
                         n, state_info, time_data, ovl_active, ovl_src, ring_end,
                         e.si, e.td, e.act, e.src, e.re);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want stimulus complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn         = 1'b0;
        ring_req     = 1'b0;
        cnt_done_req = 1'b0;
        key_cancel   = 1'b0;
        mode_state   = MS;
        mode_time    = MT;
        alarm_time   = AT;

        start("reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_rst());
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_rst());
        start("norm");
        repeat (3) idle(e_norm(1'b0));

        start("done");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, e_done(1'b0));
        repeat (7) idle(e_done(1'b0));
        repeat (2) idle(e_norm(1'b0));

        start("ring");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, e_ring(1'b1));
        for (int i = 2; i <= 16; i++) idle(e_ring(ring_ph(i)));
        idle(e_norm(1'b1));
        idle(e_norm(1'b0));

        start("preempt");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, e_done(1'b0));
        idle(e_done(1'b0));
        idle(e_done(1'b0));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, e_ring(1'b1));
        for (int i = 2; i <= 16; i++) idle(e_ring(ring_ph(i)));
        idle(e_done(1'b1));
        repeat (7) idle(e_done(1'b0));
        repeat (2) idle(e_norm(1'b0));

        start("simul_cancel");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, e_ring(1'b1));
        for (int i = 2; i <= 5; i++) idle(e_ring(ring_ph(i)));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, e_done(1'b1));
        repeat (7) idle(e_done(1'b0));
        idle(e_norm(1'b0));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, e_norm(1'b0));
        repeat (2) idle(e_norm(1'b0));

        start("ring_retrig");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, e_ring(1'b1));
        for (int i = 2; i <= 6; i++) idle(e_ring(ring_ph(i)));
        cyc(1'b1, 1'b1, 1'b0, 1'b1, e_ring(1'b1));
        for (int i = 2; i <= 3; i++) idle(e_ring(ring_ph(i)));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, e_norm(1'b1));
        idle(e_norm(1'b0));

        start("done_retrig");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, e_done(1'b0));
        repeat (3) idle(e_done(1'b0));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, e_done(1'b0));
        repeat (7) idle(e_done(1'b0));
        idle(e_norm(1'b0));

        start("reset_mid");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, e_ring(1'b1));
        idle(e_ring(1'b1));
        idle(e_ring(1'b1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_rst());
        repeat (10) idle(e_norm(1'b0));

        @(negedge clk_sys);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
